data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory target for the CPU load/store path: accepts word read/write requests over a
//  valid/ready handshake, services them after a fixed number of wait states and returns a
//  response with read data or an error flag. It models a slow memory so that CPU-side stall
//  logic can be exercised. One request is outstanding at a time.
// PARAMETERS
//  ADDR_W       10  word-index width; DEPTH = 2**ADDR_W words (default 1024 words = 4 KiB)
//  WAIT_CYCLES  2   extra cycles between request acceptance and memory access (0..255)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   CPU presents a request
//  req_ready    out  1   responder can accept; transfer when req_valid && req_ready at clk edge
//  req_we       in   1   1 = store word, 0 = load word
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data
//  resp_valid   out  1   response available
//  resp_ready   in   1   CPU takes response; completes when resp_valid && resp_ready at edge
//  resp_rdata   out  32  load data (0 for stores and errors)
//  resp_err     out  1   request was misaligned or out of range
//  err_count    out  8   saturating count of error responses since reset
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, err_count=0;
//   req_ready forced 0 while rst_n low. Memory array is NOT reset (unwritten words read X).
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid at edge: latch we/addr/wdata, cnt<=WAIT_CYCLES, go BUSY.
//  - BUSY: req_ready=0. If cnt!=0: cnt<=cnt-1. If cnt==0: perform access, load resp regs,
//    go RESP. Access and resp regs update on the same edge.
//  - RESP: req_ready=0, resp_valid=1; resp_rdata/resp_err stable until handshake. On
//    resp_ready at edge: resp_valid<=0, resp_rdata<=0, resp_err<=0, go IDLE.
//  Latency: accept at edge E -> resp_valid high after edge E+WAIT_CYCLES+1. Earliest next
//   acceptance is the edge after the response handshake edge (no overlap).
//  Address check at access time on latched addr:
//   - error if addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
//   - error: no write, resp_rdata=0, resp_err=1, err_count+=1 saturating at 255.
//   - ok: index = addr[ADDR_W+1:2]; store writes mem[index] (resp_rdata=0); load returns
//     mem[index] as it was before this edge.
//  req_* inputs ignored outside IDLE; changes after acceptance do not affect the transaction.
//  resp_ready ignored outside RESP. req_valid and resp_ready may both be high; only the one
//   matching the current state acts.
//  Reset mid-operation: aborts; a store in BUSY that has not reached its access edge is
//   discarded; completed stores remain in memory.
// TESTING
//  1 Reset mid-BUSY store: drop rst_n -> resp_valid=0, req_ready=0, err_count=0 at once;
//    release -> req_ready=1 next cycle; reading the address does not return the aborted data.
//  2 WAIT_CYCLES=2: store 0xDEADBEEF @0x10 accepted at edge E -> resp_valid after E+3,
//    resp_err=0, resp_rdata=0; then load @0x10 -> resp_rdata=0xDEADBEEF, same latency.
//  3 Misaligned store 0x00000001 @0x13 -> resp_err=1, resp_rdata=0, err_count=1;
//    load @0x10 still 0xDEADBEEF.
//  4 Out of range: load @0x1000 (ADDR_W=10) -> resp_err=1, err_count=2; load @0xFFC ok.
//  5 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_rdata held,
//    req_ready=0, a concurrent req_valid is not accepted; raise resp_ready -> IDLE next edge.
//  6 WAIT_CYCLES=0 instance: back-to-back loads with req_valid and resp_ready held high ->
//    one response every 3 cycles, latency 1; 256 bad requests -> err_count saturates at 255.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: slow word-addressed data memory behind a valid/ready request/response handshake
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake; i_req_we, i_req_addr (byte), i_req_wdata
//   o_resp_valid/i_resp_ready response handshake; o_resp_rdata, o_resp_err
//   o_err_count               saturating count of error responses since reset
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [7:0]  o_err_count
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;
  logic [7:0]          r_err_count;
  logic [7:0]          r_cnt;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem [2**ADDR_W];
  logic                w_acc;
  logic                w_err;
  logic [ADDR_W-1:0]   w_idx;
  assign w_acc = (r_state == BUSY) && (r_cnt == 8'd0);
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);
  assign w_idx = r_addr[ADDR_W+1:2];
  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_err_count  = r_err_count;
  // Memory is never reset; reset forces IDLE asynchronously, so an in-flight store cannot land.
  always_ff @(posedge i_clk) begin
    if (w_acc && !w_err && r_we) r_mem[w_idx] <= r_wdata;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_err_count  <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // ready comes up one edge after reset release, then stays high while idle
          r_req_ready <= 1'b1;
          if (r_req_ready && i_req_valid) begin
            r_we        <= i_req_we;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_cnt       <= 8'(WAIT_CYCLES);
            r_req_ready <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
          else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
            if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder with 2 wait states and with none
module tb_data_mem_responder;
  logic        clk;
  logic        rst_na, valid_a, ready_a, we_a, resp_valid_a, resp_ready_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [7:0]  cnt_a;
  logic        rst_nb, valid_b, ready_b, we_b, resp_valid_b, resp_ready_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [7:0]  cnt_b;
  int          n_cmp = 0;
  int          n_bad = 0;
  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_na), .i_req_valid(valid_a), .o_req_ready(ready_a),
    .i_req_we(we_a), .i_req_addr(addr_a), .i_req_wdata(wdata_a),
    .o_resp_valid(resp_valid_a), .i_resp_ready(resp_ready_a), .o_resp_rdata(rdata_a),
    .o_resp_err(err_a), .o_err_count(cnt_a));
  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_nb), .i_req_valid(valid_b), .o_req_ready(ready_b),
    .i_req_we(we_b), .i_req_addr(addr_b), .i_req_wdata(wdata_b),
    .o_resp_valid(resp_valid_b), .i_resp_ready(resp_ready_b), .o_resp_rdata(rdata_b),
    .o_resp_err(err_b), .o_err_count(cnt_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One full transaction on dut_a: checks the 3-edge latency, the response and the return to idle.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic exp_err, output logic [31:0] rd);
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(ready_a), 32'd1);
    valid_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    @(posedge clk);
    #1 valid_a = 1'b0; we_a = ~we; addr_a = 32'h0; wdata_a = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, ".early"}, 32'(resp_valid_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".resp_valid"}, 32'(resp_valid_a), 32'd1);
    chk({tag, ".resp_err"}, 32'(err_a), 32'(exp_err));
    chk({tag, ".busy_ready"}, 32'(ready_a), 32'd0);
    rd = rdata_a;
    resp_ready_a = 1'b1;
    @(posedge clk);
    #1 resp_ready_a = 1'b0;
    @(negedge clk);
    chk({tag, ".done_valid"}, 32'(resp_valid_a), 32'd0);
    chk({tag, ".done_rdata"}, rdata_a, 32'd0);
    chk({tag, ".done_ready"}, 32'(ready_a), 32'd1);
  endtask
  initial begin
    logic [31:0] rd;
    int          n_resp;
    rst_na = 1'b0; valid_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; resp_ready_a = 1'b0;
    rst_nb = 1'b0; valid_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; resp_ready_b = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", 32'(ready_a), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid_a), 32'd0);
    chk("rst.rdata", rdata_a, 32'd0);
    chk("rst.err", 32'(err_a), 32'd0);
    chk("rst.err_count", 32'(cnt_a), 32'd0);
    rst_na = 1'b1;
    @(negedge clk);
    chk("rel.req_ready", 32'(ready_a), 32'd1);
    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    chk("st10.rdata", rd, 32'd0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("ld10.rdata", rd, 32'hDEADBEEF);
    txn("st13", 1'b1, 32'h13, 32'h1, 1'b1, rd);
    chk("st13.rdata", rd, 32'd0);
    chk("st13.err_count", 32'(cnt_a), 32'd1);
    txn("ld10b", 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("ld10b.rdata", rd, 32'hDEADBEEF);
    txn("ld1000", 1'b0, 32'h1000, 32'h0, 1'b1, rd);
    chk("ld1000.rdata", rd, 32'd0);
    chk("ld1000.err_count", 32'(cnt_a), 32'd2);
    txn("stffc", 1'b1, 32'hFFC, 32'h12345678, 1'b0, rd);
    txn("ldffc", 1'b0, 32'hFFC, 32'h0, 1'b0, rd);
    chk("ldffc.rdata", rd, 32'h12345678);
    chk("ldffc.err_count", 32'(cnt_a), 32'd2);
    // backpressure: response held for 5 cycles while a competing store is offered
    @(negedge clk);
    valid_a = 1'b1; we_a = 1'b0; addr_a = 32'h10;
    @(posedge clk);
    #1 valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 valid_a = 1'b1; we_a = 1'b1; addr_a = 32'h10; wdata_a = 32'h0000_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.resp_valid", 32'(resp_valid_a), 32'd1);
      chk("bp.rdata", rdata_a, 32'hDEADBEEF);
      chk("bp.req_ready", 32'(ready_a), 32'd0);
    end
    resp_ready_a = 1'b1;
    @(posedge clk);
    #1 resp_ready_a = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    chk("bp.idle_valid", 32'(resp_valid_a), 32'd0);
    chk("bp.idle_ready", 32'(ready_a), 32'd1);
    txn("bp.ld10", 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("bp.ld10.rdata", rd, 32'hDEADBEEF);
    // reset in the middle of a store's wait states
    @(negedge clk);
    valid_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hCAFEF00D;
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_na = 1'b0;
    #1;
    chk("abort.resp_valid", 32'(resp_valid_a), 32'd0);
    chk("abort.req_ready", 32'(ready_a), 32'd0);
    chk("abort.err_count", 32'(cnt_a), 32'd0);
    @(negedge clk);
    rst_na = 1'b1;
    @(negedge clk);
    chk("abort.rel_ready", 32'(ready_a), 32'd1);
    txn("abort.ld20", 1'b0, 32'h20, 32'h0, 1'b0, rd);
    n_cmp++;
    assert (rd !== 32'hCAFEF00D) else begin
      n_bad++;
      $error("FAIL abort.ld20.rdata: observed %h expected not cafef00d", rd);
    end
    txn("abort.ld10", 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("abort.ld10.rdata", rd, 32'hDEADBEEF);
    // zero-wait instance: bad loads streamed with both handshakes held high
    @(negedge clk);
    valid_b = 1'b1; we_b = 1'b0; addr_b = 32'h1000; resp_ready_b = 1'b1; rst_nb = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("b.valid%0d", k), 32'(resp_valid_b), 32'((k % 3) == 0));
      chk($sformatf("b.ready%0d", k), 32'(ready_b), 32'((k % 3) == 1));
      if (k == 3) begin
        chk("b.err", 32'(err_b), 32'd1);
        chk("b.rdata", rdata_b, 32'd0);
      end
    end
    chk("b.err_count3", 32'(cnt_b), 32'd3);
    n_resp = 3;
    for (int i = 0; i < 1000 && n_resp < 256; i++) begin
      @(negedge clk);
      if (resp_valid_b) n_resp++;
      if (n_resp == 256) valid_b = 1'b0;
    end
    chk("b.n_resp", 32'(n_resp), 32'd256);
    chk("b.err_count_sat", 32'(cnt_b), 32'd255);
    repeat (2) @(negedge clk);
    chk("b.final_valid", 32'(resp_valid_b), 32'd0);
    chk("b.final_count", 32'(cnt_b), 32'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
